// File: rtl/sdram_data_handles_if.sv
// Byte-stream and SDRAM-controller signals of the UART-to-SDRAM bridge.
// slave: the bridge itself. master: the environment (UART pair + controller).
interface sdram_data_handles_if;
  logic [7:0]  din;
  logic        din_vld;
  logic        wr_req;
  logic        rd_req;
  logic [8:0]  wr_cnt;
  logic [22:0] wr_addr;
  logic [47:0] wr_data;
  logic [47:0] sd_data;
  logic        sd_data_vld;
  logic        rdy;
  logic [7:0]  dout;
  logic        dout_vld;

  modport slave (
    input  din, din_vld, sd_data, sd_data_vld, rdy,
    output wr_req, rd_req, wr_cnt, wr_addr, wr_data, dout, dout_vld
  );

  modport master (
    output din, din_vld, sd_data, sd_data_vld, rdy,
    input  wr_req, rd_req, wr_cnt, wr_addr, wr_data, dout, dout_vld
  );
endinterface

// File: rtl/sdram_data_handles.sv
// UART-to-SDRAM command bridge: parses a byte-serial command frame, packs
// write data into 48-bit words, and buffers/serialises read-return words
// back to the UART TX side one byte at a time.
module sdram_data_handles #(
  parameter logic [7:0] CMD_WR        = 8'hDD,
  parameter logic [7:0] CMD_RD        = 8'hFF,
  parameter int         RD_FIFO_DEPTH = 512
) (
  input logic                 clk,
  input logic                 rst,
  sdram_data_handles_if.slave bus
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RD_FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(RD_FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_BANK, S_ROW_H, S_ROW_L,
    S_COL_H, S_COL_L, S_TAIL, S_WDATA
  } state_t;

  // Parser / write-path state
  state_t      state_q;
  logic        is_rd_q;
  logic        cnt_h_q;
  logic [7:0]  cnt_l_q;
  logic [1:0]  bank_q;
  logic [3:0]  row_h_q;
  logic [7:0]  row_l_q;
  logic        col_h_q;
  logic [8:0]  wr_cnt_q;
  logic [22:0] wr_addr_q;
  logic [39:0] asm_q;
  logic [2:0]  byte_idx_q;
  logic [8:0]  word_cnt_q;
  logic [47:0] wr_data_q;
  logic        wr_req_q;
  logic        rd_req_q;

  // Read-return FIFO and byte serialiser state
  logic [47:0]    mem_q [RD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   fill_q;
  logic [PTR_W:0]   fill_d;
  logic             push_d;
  logic             pop_d;
  logic             ser_busy_q;
  logic [2:0]       ser_idx_q;
  logic [47:0]      ser_word_q;
  logic [7:0]       dout_q;
  logic             dout_vld_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Frame parser and write-word assembler; request strobes are one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      wr_cnt_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      if (bus.din_vld) begin
        case (state_q)
          S_IDLE: begin
            if (bus.din == CMD_WR || bus.din == CMD_RD) begin
              is_rd_q <= (bus.din == CMD_RD);
              state_q <= S_CNT_H;
            end
          end
          S_CNT_H: begin cnt_h_q <= bus.din[0];   state_q <= S_CNT_L; end
          S_CNT_L: begin cnt_l_q <= bus.din;      state_q <= S_BANK;  end
          S_BANK:  begin bank_q  <= bus.din[1:0]; state_q <= S_ROW_H; end
          S_ROW_H: begin row_h_q <= bus.din[3:0]; state_q <= S_ROW_L; end
          S_ROW_L: begin row_l_q <= bus.din;      state_q <= S_COL_H; end
          S_COL_H: begin col_h_q <= bus.din[0];   state_q <= S_COL_L; end
          S_COL_L: begin
            wr_cnt_q  <= {cnt_h_q, cnt_l_q};
            wr_addr_q <= {bank_q, row_h_q, row_l_q, col_h_q, bus.din};
            state_q   <= S_TAIL;
          end
          S_TAIL: begin
            // Trailer value is don't-care; a zero-length frame issues nothing
            if (wr_cnt_q == '0) begin
              state_q <= S_IDLE;
            end else if (is_rd_q) begin
              rd_req_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              byte_idx_q <= '0;
              word_cnt_q <= '0;
              state_q    <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (byte_idx_q == 3'd5) begin
              wr_data_q  <= {asm_q, bus.din};
              wr_req_q   <= 1'b1;
              byte_idx_q <= '0;
              word_cnt_q <= word_cnt_q + 1'b1;
              if (word_cnt_q + 9'd1 == wr_cnt_q) state_q <= S_IDLE;
            end else begin
              asm_q      <= {asm_q[31:0], bus.din};
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO handshake: drop pushes when full, pop only into an idle serialiser
  always_comb begin
    push_d = bus.sd_data_vld && (fill_q != FULL_LVL);
    pop_d  = !ser_busy_q && (fill_q != '0);
    fill_d = fill_q;
    case ({push_d, pop_d})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Read-return storage
  always_ff @(posedge clk) begin
    if (push_d) mem_q[wr_ptr_q] <= bus.sd_data;
  end

  // FIFO pointers and MSB-first byte serialiser with a mandatory gap cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ser_busy_q <= 1'b0;
      ser_idx_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      dout_vld_q <= 1'b0;
      if (push_d) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_d) begin
        ser_word_q <= mem_q[rd_ptr_q];
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        ser_busy_q <= 1'b1;
        ser_idx_q  <= '0;
      end else if (ser_busy_q && bus.rdy && !dout_vld_q) begin
        dout_q     <= ser_word_q[47:40];
        dout_vld_q <= 1'b1;
        ser_word_q <= {ser_word_q[39:0], 8'h00};
        if (ser_idx_q == 3'd5) ser_busy_q <= 1'b0;
        else                   ser_idx_q  <= ser_idx_q + 1'b1;
      end
    end
  end

  assign bus.wr_req   = wr_req_q;
  assign bus.rd_req   = rd_req_q;
  assign bus.wr_cnt   = wr_cnt_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;

endmodule

// File: tb/tb_sdram_data_handles.sv
// Directed bench for sdram_data_handles: header frames from a vector table,
// plus hand-written write, read-drain, rdy-stall and reset-abort sequences.
module tb_sdram_data_handles;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_data_handles_if bus ();

  sdram_data_handles dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [71:0] hdr;
    logic        rd;
    logic [8:0]  cnt;
    logic [22:0] addr;
  } vec_t;

  vec_t vecs [5];
  int   n_vec = 0;
  int   n_bad = 0;

  // Byte collector, gap checker and request pulse counters
  logic [7:0] rx_q [$];
  int  gap_err   = 0;
  int  rd_pulses = 0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1) begin
      rx_q.push_back(bus.dout);
      if (prev_vld) gap_err++;
    end
    if (bus.rd_req === 1'b1) rd_pulses++;
    prev_vld = (bus.dout_vld === 1'b1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.din     = b;
    bus.din_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
  endtask

  task automatic send_hdr(input logic [71:0] hdr);
    for (int i = 0; i < 9; i++) send_byte(hdr[71 - 8*i -: 8]);
  endtask

  task automatic apply_vec(input int k);
    send_hdr(vecs[k].hdr);
    check($sformatf("v%0d_rd_req", k), 64'(bus.rd_req), 64'(vecs[k].rd));
    check($sformatf("v%0d_wr_req", k), 64'(bus.wr_req), 64'd0);
    check($sformatf("v%0d_wr_cnt", k), 64'(bus.wr_cnt), 64'(vecs[k].cnt));
    check($sformatf("v%0d_wr_addr", k), 64'(bus.wr_addr), 64'(vecs[k].addr));
    tick(1);
    check($sformatf("v%0d_rd_req_end", k), 64'(bus.rd_req), 64'd0);
  endtask

  task automatic push_word(input logic [47:0] w);
    bus.sd_data     = w;
    bus.sd_data_vld = 1'b1;
    tick(1);
    bus.sd_data_vld = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while (rx_q.size() < n && k < 2000) begin
      tick(1);
      k++;
    end
    check(name, 64'(rx_q.size()), 64'(n));
  endtask

  initial begin
    logic [47:0] w;
    int          rd0;

    vecs[0] = '{hdr: 72'hFF_00_06_02_00_05_00_01_01, rd: 1'b1, cnt: 9'h006, addr: 23'h400A01};
    vecs[1] = '{hdr: 72'hFF_01_FF_03_0F_FF_01_FF_01, rd: 1'b1, cnt: 9'h1FF, addr: 23'h7FFFFF};
    vecs[2] = '{hdr: 72'hFF_FE_10_FD_F2_34_FE_80_01, rd: 1'b1, cnt: 9'h010, addr: 23'h246880};
    vecs[3] = '{hdr: 72'hFF_00_00_01_00_02_00_03_01, rd: 1'b0, cnt: 9'h000, addr: 23'h200403};
    vecs[4] = '{hdr: 72'hDD_00_00_02_00_01_00_02_01, rd: 1'b0, cnt: 9'h000, addr: 23'h400202};

    rst             = 1'b1;
    bus.din         = '0;
    bus.din_vld     = 1'b0;
    bus.sd_data     = '0;
    bus.sd_data_vld = 1'b0;
    bus.rdy         = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_wr_req", 64'(bus.wr_req), 64'd0);
    check("rst_rd_req", 64'(bus.rd_req), 64'd0);
    check("rst_wr_cnt", 64'(bus.wr_cnt), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_dout", 64'({bus.dout_vld, bus.dout}), 64'd0);

    // Header table
    for (int k = 0; k < 5; k++) apply_vec(k);

    // Single-word write
    send_hdr(72'hDD_00_01_00_00_00_00_00_01);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h0A + 8'(i));
      check($sformatf("w1_req_b%0d", i), 64'(bus.wr_req), 64'(i == 5));
    end
    check("w1_data", 64'(bus.wr_data), 64'h0A0B0C0D0E0F);
    check("w1_addr", 64'(bus.wr_addr), 64'd0);
    check("w1_cnt", 64'(bus.wr_cnt), 64'd1);
    tick(1);
    check("w1_req_end", 64'(bus.wr_req), 64'd0);

    // Two-word write; strobe after 6th and 12th byte only
    send_hdr(72'hDD_00_02_01_00_03_00_04_01);
    check("w2_cnt", 64'(bus.wr_cnt), 64'd2);
    check("w2_addr", 64'(bus.wr_addr), 64'h200604);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(i + 1));
      check($sformatf("w2_req_b%0d", i), 64'(bus.wr_req), 64'(i == 5 || i == 11));
      if (i == 5 || i == 8)
        check($sformatf("w2_data_b%0d", i), 64'(bus.wr_data), 64'h010203040506);
    end
    check("w2_data_last", 64'(bus.wr_data), 64'h0708090A0B0C);
    tick(1);
    check("w2_req_end", 64'(bus.wr_req), 64'd0);

    // Parser must be idle again: a read frame is recognised
    apply_vec(0);

    // Read with 6 back-to-back return words, drained with rdy high
    rx_q.delete();
    bus.rdy = 1'b1;
    apply_vec(0);
    tick(2);
    for (int i = 0; i < 6; i++) begin
      bus.sd_data     = 48'(10 + i);
      bus.sd_data_vld = 1'b1;
      tick(1);
    end
    bus.sd_data_vld = 1'b0;
    wait_bytes(36, "drain_count");
    for (int i = 0; i < 36 && i < rx_q.size(); i++)
      check($sformatf("drain_b%0d", i), 64'(rx_q[i]), (i % 6 == 5) ? 64'(10 + i / 6) : 64'd0);
    check("drain_gap", 64'(gap_err), 64'd0);

    // Junk byte in IDLE is ignored
    send_byte(8'h55);
    apply_vec(0);

    // rdy held low stalls the serialiser without losing bytes
    rx_q.delete();
    bus.rdy = 1'b0;
    push_word(48'h112233445566);
    push_word(48'hA1B2C3D4E5F6);
    tick(30);
    check("stall_no_bytes", 64'(rx_q.size()), 64'd0);
    bus.rdy = 1'b1;
    wait_bytes(12, "stall_count");
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      w = (i < 6) ? 48'h112233445566 : 48'hA1B2C3D4E5F6;
      check($sformatf("stall_b%0d", i), 64'(rx_q[i]), 64'(w[47 - 8*(i % 6) -: 8]));
    end
    check("stall_dout_hold", 64'(bus.dout), 64'hF6);
    check("stall_gap", 64'(gap_err), 64'd0);

    // Reset mid-frame aborts; remaining header bytes are ignored
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h06);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_wr_cnt", 64'(bus.wr_cnt), 64'd0);
    check("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
    rd0 = rd_pulses;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    tick(3);
    check("abort_no_rd", 64'(rd_pulses - rd0), 64'd0);
    check("abort_wr_cnt_hold", 64'(bus.wr_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
